// File: rtl/seg7_pkg.sv
// Shared seven-segment code table (GFEDCBA, active-high) used by both the
// hex-to-segment encoder and the scan decoder, plus decoder-side types.
package seg7_pkg;

    // Index = nibble value; the leftmost entry is index 15 (F).
    localparam logic [15:0][6:0] SEG_CODE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_UNSTABLE,
        ST_SETTLING,
        ST_LOCKED
    } stab_state_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nib;
    } seg_dec_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        return SEG_CODE[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display-bus side (An/SSeg) and recovered-frame side of the scan decoder.
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   An;
    logic [7:0]          SSeg;
    logic [4*DIGITS-1:0] Hex;
    logic [DIGITS-1:0]   DPOut;
    logic [DIGITS-1:0]   Blank;
    logic                Err;
    logic                Valid;
    logic                Stale;

    modport master (
        output An, SSeg,
        input  Hex, DPOut, Blank, Err, Valid, Stale
    );

    modport slave (
        input  An, SSeg,
        output Hex, DPOut, Blank, Err, Valid, Stale
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational 7-bit GFEDCBA pattern to {legal, blank, nibble}.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output seg_dec_t   o_dec
);
    logic [3:0] w_nib;
    logic       w_legal;
    logic       w_blank;

    always_comb begin
        w_nib   = 4'h0;
        w_legal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == SEG_CODE[i]) begin
                w_legal = 1'b1;
                w_nib   = 4'(i);
            end
        end
        w_blank = (i_seg == SEG_BLANK);
        if (w_blank) w_legal = 1'b1;
    end

    assign o_dec = '{legal: w_legal, blank: w_blank, nib: w_nib};
endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed seven-segment bus: waits for each
// digit to settle, decodes it, and publishes a frame once every digit is seen.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_decoder_if.slave bus
);
    localparam int            CW       = $clog2(SETTLE + 1);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(SETTLE);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT);

    logic [DIGITS-1:0]      r_an_q;
    logic [7:0]             r_sseg_q;
    stab_state_t            r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic                   w_onehot, w_stable, w_capture, w_publish;
    seg_dec_t               w_dec;

    logic [DIGITS-1:0][3:0] r_sh_nib;
    logic [DIGITS-1:0]      r_sh_dp, r_sh_blank, r_sh_err, r_seen;
    logic [4*DIGITS-1:0]    r_hex;
    logic [DIGITS-1:0]      r_dp, r_blank;
    logic                   r_err, r_valid;
    logic [TW-1:0]          r_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an_q   <= '0;
            r_sseg_q <= '0;
            r_state  <= ST_UNSTABLE;
            r_cnt    <= '0;
        end else begin
            r_an_q   <= bus.An;
            r_sseg_q <= bus.SSeg;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign w_onehot = (bus.An != '0) && ((bus.An & (bus.An - DIGITS'(1))) == '0);
    assign w_stable = w_onehot && (bus.An == r_an_q) && (bus.SSeg == r_sseg_q);

    // Capture fires only on the SETTLING->LOCKED transition, so a held digit
    // is written exactly once until the bus changes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        if (!w_stable) begin
            w_state_nxt = ST_UNSTABLE;
            w_cnt_nxt   = '0;
        end else if (r_state != ST_LOCKED) begin
            if (r_cnt == CNT_LAST) begin
                w_state_nxt = ST_LOCKED;
                w_cnt_nxt   = CNT_SAT;
                w_capture   = 1'b1;
            end else begin
                w_state_nxt = ST_SETTLING;
                w_cnt_nxt   = r_cnt + CW'(1);
            end
        end
    end

    seg7_decode u_dec (
        .i_seg (r_sseg_q[6:0]),
        .o_dec (w_dec)
    );

    assign w_publish = &r_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_nib   <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
            r_sh_err   <= '0;
            r_seen     <= '0;
            r_hex      <= '0;
            r_dp       <= '0;
            r_blank    <= '0;
            r_err      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (w_publish) begin
                r_hex   <= r_sh_nib;
                r_dp    <= r_sh_dp;
                r_blank <= r_sh_blank;
                r_err   <= |r_sh_err;
            end
            // A capture coinciding with publish starts the next frame's mask.
            r_seen <= ({DIGITS{!w_publish}} & r_seen) | ({DIGITS{w_capture}} & r_an_q);
            for (int i = 0; i < DIGITS; i++) begin
                if (w_capture && r_an_q[i]) begin
                    r_sh_nib[i]   <= w_dec.nib;
                    r_sh_dp[i]    <= r_sseg_q[7];
                    r_sh_blank[i] <= w_dec.blank;
                    r_sh_err[i]   <= !w_dec.legal;
                end else if (w_publish) begin
                    r_sh_err[i]   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_capture) r_idle <= '0;
        else if (r_idle != IDLE_MAX) r_idle <= r_idle + TW'(1);
    end

    assign bus.Hex   = r_hex;
    assign bus.DPOut = r_dp;
    assign bus.Blank = r_blank;
    assign bus.Err   = r_err;
    assign bus.Valid = r_valid;
    assign bus.Stale = (r_idle == IDLE_MAX);
endmodule
